// File: rtl/commit_trace_fifo.sv
// rtl/commit_trace_fifo.sv - retire-trace record FIFO with halt drain sequencing
// Captures retiring instructions as numbered trace records for an external consumer.
module commit_trace_fifo #(
  parameter int DEPTH  = 8,
  parameter int PC_W   = 16,
  parameter int DATA_W = 16,
  parameter int REG_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              commit_valid,
  input  logic [PC_W-1:0]   commit_pc,
  input  logic [PC_W-1:0]   commit_inst,
  input  logic              commit_regwrite,
  input  logic [REG_W-1:0]  commit_wreg,
  input  logic [DATA_W-1:0] commit_wdata,
  input  logic              commit_memread,
  input  logic              commit_memwrite,
  input  logic [DATA_W-1:0] commit_memaddr,
  input  logic [DATA_W-1:0] commit_memdata,
  input  logic              commit_halt,
  output logic              rec_valid,
  input  logic              rec_ready,
  output logic [2:0]        rec_kind,
  output logic [31:0]       rec_inum,
  output logic [PC_W-1:0]   rec_pc,
  output logic [REG_W-1:0]  rec_wreg,
  output logic [DATA_W-1:0] rec_wdata,
  output logic [DATA_W-1:0] rec_addr,
  output logic [DATA_W-1:0] rec_mdata,
  output logic              full,
  output logic              overflow,
  output logic [31:0]       inst_count,
  output logic [31:0]       cycle_count,
  output logic              done
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  localparam logic [2:0] KIND_NOP  = 3'd0;
  localparam logic [2:0] KIND_REG  = 3'd1;
  localparam logic [2:0] KIND_LD   = 3'd2;
  localparam logic [2:0] KIND_ST   = 3'd3;
  localparam logic [2:0] KIND_STU  = 3'd4;
  localparam logic [2:0] KIND_HALT = 3'd5;

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

  state_t state, state_next;

  logic [2:0]        kind_mem  [DEPTH];
  logic [31:0]       inum_mem  [DEPTH];
  logic [PC_W-1:0]   pc_mem    [DEPTH];
  logic [REG_W-1:0]  wreg_mem  [DEPTH];
  logic [DATA_W-1:0] wdata_mem [DEPTH];
  logic [DATA_W-1:0] addr_mem  [DEPTH];
  logic [DATA_W-1:0] mdata_mem [DEPTH];

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          sample, push, pop;
  logic [2:0]    push_kind;
  logic          unused_inst;

  // The instruction word is not part of the record layout.
  assign unused_inst = ^commit_inst;

  assign rec_valid = (count != '0);
  assign full      = (count == FULL_COUNT);
  assign done      = (state == DONE);

  assign sample = commit_valid && (state == RUN);
  assign pop    = rec_valid && rec_ready;
  assign push   = sample && (!full || pop);

  always_comb begin
    push_kind = KIND_NOP;
    if (commit_halt)                           push_kind = KIND_HALT;
    else if (commit_regwrite && commit_memwrite) push_kind = KIND_STU;
    else if (commit_memwrite)                  push_kind = KIND_ST;
    else if (commit_regwrite && commit_memread) push_kind = KIND_LD;
    else if (commit_regwrite)                  push_kind = KIND_REG;
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (sample && commit_halt) state_next = DRAIN;
      DRAIN:   if (count == '0) state_next = DONE;
      DONE:    state_next = DONE;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      overflow    <= 1'b0;
      inst_count  <= '0;
      cycle_count <= '0;
    end else begin
      state <= state_next;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A dropped commit still consumes its number so the gap is visible downstream.
      if (sample) begin
        inst_count <= inst_count + 32'd1;
        if (!push) overflow <= 1'b1;
      end
      if (state != DONE) cycle_count <= cycle_count + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      kind_mem[wr_ptr]  <= push_kind;
      inum_mem[wr_ptr]  <= inst_count;
      pc_mem[wr_ptr]    <= commit_pc;
      wreg_mem[wr_ptr]  <= commit_wreg;
      wdata_mem[wr_ptr] <= commit_wdata;
      addr_mem[wr_ptr]  <= commit_memaddr;
      mdata_mem[wr_ptr] <= commit_memdata;
    end
  end

  assign rec_kind  = kind_mem[rd_ptr];
  assign rec_inum  = inum_mem[rd_ptr];
  assign rec_pc    = pc_mem[rd_ptr];
  assign rec_wreg  = wreg_mem[rd_ptr];
  assign rec_wdata = wdata_mem[rd_ptr];
  assign rec_addr  = addr_mem[rd_ptr];
  assign rec_mdata = mdata_mem[rd_ptr];

endmodule

// File: tb/tb_commit_trace_fifo.sv
// tb/tb_commit_trace_fifo.sv - scoreboard and vector-table bench for commit_trace_fifo
// A reference queue plus state model predicts every record and status output.
module tb_commit_trace_fifo;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        commit_valid = 1'b0;
  logic [15:0] commit_pc = '0, commit_inst = '0;
  logic        commit_regwrite = 1'b0;
  logic [2:0]  commit_wreg = '0;
  logic [15:0] commit_wdata = '0;
  logic        commit_memread = 1'b0, commit_memwrite = 1'b0;
  logic [15:0] commit_memaddr = '0, commit_memdata = '0;
  logic        commit_halt = 1'b0;
  logic        rec_valid, rec_ready = 1'b0;
  logic [2:0]  rec_kind;
  logic [31:0] rec_inum;
  logic [15:0] rec_pc;
  logic [2:0]  rec_wreg;
  logic [15:0] rec_wdata, rec_addr, rec_mdata;
  logic        full, overflow, done;
  logic [31:0] inst_count, cycle_count;

  commit_trace_fifo #(.DEPTH(DEPTH), .PC_W(16), .DATA_W(16), .REG_W(3)) dut (
    .clk(clk), .rst(rst),
    .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_inst(commit_inst),
    .commit_regwrite(commit_regwrite), .commit_wreg(commit_wreg), .commit_wdata(commit_wdata),
    .commit_memread(commit_memread), .commit_memwrite(commit_memwrite),
    .commit_memaddr(commit_memaddr), .commit_memdata(commit_memdata), .commit_halt(commit_halt),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_kind(rec_kind), .rec_inum(rec_inum),
    .rec_pc(rec_pc), .rec_wreg(rec_wreg), .rec_wdata(rec_wdata), .rec_addr(rec_addr),
    .rec_mdata(rec_mdata), .full(full), .overflow(overflow), .inst_count(inst_count),
    .cycle_count(cycle_count), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  kind;
    logic [31:0] inum;
    logic [15:0] pc;
    logic [2:0]  wreg;
    logic [15:0] wdata, addr, mdata;
  } rec_t;

  typedef struct {
    logic        rw, mr, mw, halt;
    logic [15:0] pc;
    logic [2:0]  wreg;
    logic [15:0] wdata, addr, mdata;
    logic [2:0]  kind;
  } vec_t;

  rec_t        sb[$];
  int          mstate;  // 0 RUN, 1 DRAIN, 2 DONE
  logic [31:0] m_inst, m_cyc;
  logic        m_ovf;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".rec_valid"}, {31'd0, rec_valid}, {31'd0, sb.size() != 0});
    chk({tag, ".full"}, {31'd0, full}, {31'd0, sb.size() == DEPTH});
    chk({tag, ".overflow"}, {31'd0, overflow}, {31'd0, m_ovf});
    chk({tag, ".inst_count"}, inst_count, m_inst);
    chk({tag, ".cycle_count"}, cycle_count, m_cyc);
    chk({tag, ".done"}, {31'd0, done}, {31'd0, mstate == 2});
  endtask

  // Called at posedge+1; drives one cycle, predicts the edge, checks after it.
  task automatic cycle(input string tag, input logic valid, input logic ready, input vec_t v);
    logic pop_m, samp, push_m;
    int   nstate;
    commit_valid = valid; rec_ready = ready;
    commit_regwrite = v.rw; commit_memread = v.mr; commit_memwrite = v.mw; commit_halt = v.halt;
    commit_pc = v.pc; commit_inst = ~v.pc; commit_wreg = v.wreg; commit_wdata = v.wdata;
    commit_memaddr = v.addr; commit_memdata = v.mdata;
    #3;
    pop_m = (sb.size() != 0) && ready;
    if (pop_m) begin
      chk({tag, ".kind"}, {29'd0, rec_kind}, {29'd0, sb[0].kind});
      chk({tag, ".inum"}, rec_inum, sb[0].inum);
      chk({tag, ".pc"}, {16'd0, rec_pc}, {16'd0, sb[0].pc});
      chk({tag, ".wreg"}, {29'd0, rec_wreg}, {29'd0, sb[0].wreg});
      chk({tag, ".wdata"}, {16'd0, rec_wdata}, {16'd0, sb[0].wdata});
      chk({tag, ".addr"}, {16'd0, rec_addr}, {16'd0, sb[0].addr});
      chk({tag, ".mdata"}, {16'd0, rec_mdata}, {16'd0, sb[0].mdata});
    end
    samp   = valid && (mstate == 0);
    push_m = samp && ((sb.size() < DEPTH) || pop_m);
    nstate = mstate;
    if (mstate == 0 && samp && v.halt) nstate = 1;
    else if (mstate == 1 && sb.size() == 0) nstate = 2;
    if (mstate != 2) m_cyc++;
    if (samp && !push_m) m_ovf = 1'b1;
    if (pop_m) void'(sb.pop_front());
    if (push_m) sb.push_back('{v.kind, m_inst, v.pc, v.wreg, v.wdata, v.addr, v.mdata});
    if (samp) m_inst++;
    mstate = nstate;
    @(posedge clk);
    #1;
    check_state(tag);
  endtask

  function automatic vec_t reg_vec(input logic [15:0] pc, input logic [15:0] d);
    vec_t v;
    v = '{1'b1, 1'b0, 1'b0, 1'b0, pc, pc[2:0], d, 16'h0, 16'h0, 3'd1};
    return v;
  endfunction

  function automatic vec_t halt_vec(input logic [15:0] pc);
    vec_t v;
    v = '{1'b1, 1'b0, 1'b1, 1'b1, pc, 3'd7, 16'h00FF, 16'h0044, 16'h0055, 3'd5};
    return v;
  endfunction

  task automatic idle(input string tag, input logic ready);
    vec_t z;
    z = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 3'd0, 16'h0, 16'h0, 16'h0, 3'd0};
    cycle(tag, 1'b0, ready, z);
  endtask

  task automatic do_reset(input string tag);
    commit_valid = 1'b0; rec_ready = 1'b0;
    rst = 1'b1;
    sb.delete(); mstate = 0; m_inst = '0; m_cyc = '0; m_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_state(tag);
  endtask

  vec_t tbl[7];

  initial begin
    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd3, 16'h0005, 16'h0000, 16'h0000, 3'd1};
    tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0002, 3'd0, 16'h0000, 16'h0000, 16'h0000, 3'd0};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0004, 3'd1, 16'h1111, 16'h0020, 16'h1234, 3'd3};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0006, 3'd2, 16'h2222, 16'h0010, 16'hBEEF, 3'd4};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0008, 3'd5, 16'hCAFE, 16'h0030, 16'h0000, 3'd2};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h000A, 3'd6, 16'h0000, 16'h0040, 16'h0000, 3'd0};
    tbl[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h000C, 3'd4, 16'h3333, 16'h0050, 16'h5A5A, 3'd4};

    do_reset("reset");
    chk("reset.cycle_count", cycle_count, 32'd0);

    for (int i = 0; i < 7; i++) begin
      cycle($sformatf("vec%0d", i), 1'b1, 1'b1, tbl[i]);
      if (i == 0) begin
        chk("add.rec_valid", {31'd0, rec_valid}, 32'd1);
        chk("add.inum", rec_inum, 32'd0);
      end
    end
    idle("vec_flush", 1'b1);

    do_reset("ovf_reset");
    for (int i = 0; i < 10; i++) cycle($sformatf("fill%0d", i), 1'b1, 1'b0, reg_vec(16'(i * 2), 16'(i)));
    chk("ovf.full", {31'd0, full}, 32'd1);
    chk("ovf.overflow", {31'd0, overflow}, 32'd1);
    chk("ovf.inst_count", inst_count, 32'd10);
    for (int i = 0; i < 8; i++) idle($sformatf("ovf_pop%0d", i), 1'b1);
    cycle("ovf_next", 1'b1, 1'b1, reg_vec(16'h0100, 16'h00AA));
    chk("ovf_next.inum", rec_inum, 32'd10);
    idle("ovf_next_pop", 1'b1);

    do_reset("pp_reset");
    for (int i = 0; i < 8; i++) cycle($sformatf("pp_fill%0d", i), 1'b1, 1'b0, reg_vec(16'(i), 16'(i + 100)));
    cycle("pp_full", 1'b1, 1'b1, reg_vec(16'h0200, 16'h0777));
    chk("pp.full", {31'd0, full}, 32'd1);
    chk("pp.overflow", {31'd0, overflow}, 32'd0);
    for (int i = 0; i < 8; i++) idle($sformatf("pp_pop%0d", i), 1'b1);

    do_reset("halt_reset");
    for (int i = 0; i < 3; i++) cycle($sformatf("halt_q%0d", i), 1'b1, 1'b0, reg_vec(16'(i + 16), 16'(i)));
    cycle("halt", 1'b1, 1'b0, halt_vec(16'h0300));
    cycle("halt_extra", 1'b1, 1'b0, reg_vec(16'h0302, 16'h0999));
    chk("halt.inst_count", inst_count, 32'd4);
    for (int k = 0; k < 20 && mstate != 2; k++) idle($sformatf("drain%0d", k), 1'b1);
    chk("halt.done", {31'd0, done}, 32'd1);
    for (int i = 0; i < 3; i++) cycle($sformatf("done%0d", i), 1'b1, 1'b1, reg_vec(16'h0400, 16'h0001));

    do_reset("mid_reset");
    cycle("mid_q0", 1'b1, 1'b0, reg_vec(16'h0010, 16'h0011));
    cycle("mid_halt", 1'b1, 1'b0, halt_vec(16'h0012));
    #2;
    rst = 1'b1;
    #1;
    chk("mid.rec_valid", {31'd0, rec_valid}, 32'd0);
    chk("mid.done", {31'd0, done}, 32'd0);
    chk("mid.inst_count", inst_count, 32'd0);
    do_reset("mid_release");
    cycle("mid_commit", 1'b1, 1'b1, reg_vec(16'h0020, 16'h0042));
    chk("mid_commit.inum", rec_inum, 32'd0);
    idle("mid_pop", 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/commit_trace_fifo.md
COMMIT_TRACE_FIFO -- requirements
Module: commit_trace_fifo

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  DEPTH  8  record FIFO entries; power of two, 2..64
  PC_W  16  PC and instruction width
  DATA_W  16  register and memory data and address width
  REG_W  3  register index width
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  clk  in  1  sole clock; all state updates on its rising edge
  rst  in  1  asynchronous, active-high reset
  commit_valid  in  1  one instruction retires this cycle
  commit_pc, commit_inst  in  PC_W  retiring PC and instruction
  commit_regwrite  in  1  register write
  commit_wreg  in  REG_W  register index written
  commit_wdata  in  DATA_W  register write data
  commit_memread, commit_memwrite  in  1  memory read and memory write
  commit_memaddr, commit_memdata  in  DATA_W  memory address and store data
  commit_halt  in  1  retiring instruction is HALT
  rec_valid  out  1  record available at head
  rec_ready  in  1  consumer accepts head record
  rec_kind  out  3  0 NOP/branch, 1 REG, 2 LD, 3 ST, 4 STU, 5 HALT
  rec_inum  out  32  instruction number of record
  rec_pc, rec_wreg, rec_wdata, rec_addr, rec_mdata  out  field widths  captured commit fields
  full  out  1  FIFO holds DEPTH records
  overflow  out  1  sticky: at least one record dropped
  inst_count  out  32  commits accepted while RUN, dropped included
  cycle_count  out  32  cycles since reset release
  done  out  1  halt seen and FIFO drained

Function
REQ-003 Kind SHALL be decoded at push, in priority order: halt -> 5; regwrite & memwrite -> 4; memwrite -> 3; regwrite & memread -> 2; regwrite -> 1; otherwise -> 0.
REQ-004 A commit SHALL be sampled only when commit_valid=1 and state=RUN.
REQ-005 Each sampled commit SHALL get rec_inum equal to inst_count before increment, then inst_count SHALL increment by 1, wrapping modulo 2^32.
REQ-006 A sampled commit SHALL be pushed unless full=1 and no pop occurs in the same cycle.
REQ-007 A non-pushed sampled commit SHALL set overflow; its inum SHALL still be consumed, leaving a visible gap.
REQ-008 Pop SHALL occur when rec_valid=1 and rec_ready=1; the next record SHALL appear the following cycle.
REQ-009 Simultaneous push and pop when full SHALL succeed; occupancy stays DEPTH.
REQ-010 Simultaneous push and pop when empty SHALL leave the FIFO empty-then-valid: the pushed record appears the next cycle, and the pop is ignored because rec_valid=0.
REQ-011 rec_valid SHALL equal occupancy != 0; no combinational path from commit_* to rec_*, giving latency 1 cycle minimum.
REQ-012 Read and write pointers SHALL be log2(DEPTH) bits wrapping naturally; occupancy counter SHALL be log2(DEPTH)+1 bits.
REQ-013 The FSM SHALL have states RUN, DRAIN, DONE.
REQ-014 RUN -> DRAIN SHALL occur on a sampled commit with commit_halt=1, whether pushed or dropped.
REQ-015 DRAIN -> DONE SHALL occur in the cycle after occupancy reaches 0.
REQ-016 DONE SHALL be terminal until reset.
REQ-017 done SHALL equal (state==DONE).
REQ-018 In DRAIN and DONE, commit_valid SHALL be ignored: no push, no inst_count change, no overflow.
REQ-019 cycle_count SHALL increment every cycle in RUN and DRAIN, freeze in DONE, and wrap modulo 2^32.
REQ-020 FIFO storage SHALL not need reset; only its control state is reset.

Reset
REQ-021 While rst=1, asynchronously: state=RUN, pointers and occupancy=0, rec_valid=0, full=0, overflow=0, inst_count=0, cycle_count=0, done=0.
REQ-022 Reset asserted mid-drain SHALL discard all records; the first post-reset commit SHALL get inum 0.
REQ-023 rec_* data fields are don't-care while rec_valid=0.

Verification
REQ-024 ADD at PC 0x0000 writing r3=0x0005, rec_ready=1 -> next cycle rec_valid=1, kind=1, inum=0, wreg=3, wdata=0x0005.
REQ-025 DEPTH=8, rec_ready=0, 10 commits -> full=1 after 8; overflow=1; inst_count=10; popping shows inums 0..7; the next pushed commit has inum 10.
REQ-026 Full FIFO with rec_ready=1 and a commit in the same cycle -> no overflow, occupancy stays 8, the new record lands at the tail.
REQ-027 STU with regwrite=1 and memwrite=1 at addr 0x0010, data 0xBEEF -> kind=4; LD with memread=1 and regwrite=1 -> kind=2.
REQ-028 HALT with 3 records queued, then a further commit_valid -> the extra commit is ignored; done=1 one cycle after the 4th pop; cycle_count frozen thereafter.
REQ-029 rst pulsed while in DRAIN with 2 records queued -> rec_valid=0 and done=0 immediately; a following commit gets inum 0.
